// File: rtl/cmd_tree_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmd_tree_sched_if : requester-side bus of cmd_tree_sched (request/grant/done)
// Rev 1.0
// ---------------------------------------------------------------------------
interface cmd_tree_sched_if #(
  parameter int NUM_REQ         = 4,
  parameter int NUM_OUTPUT_DATA = 8,
  parameter int LEN_W           = 8
);
  logic [NUM_REQ-1:0]                 i_req;
  logic [NUM_REQ*NUM_OUTPUT_DATA-1:0] i_req_cmd;
  logic [NUM_REQ*LEN_W-1:0]           i_req_len;
  logic [NUM_REQ-1:0]                 o_grant;
  logic [NUM_REQ-1:0]                 o_done;

  modport master (
    output i_req, i_req_cmd, i_req_len,
    input  o_grant, o_done
  );

  modport slave (
    input  i_req, i_req_cmd, i_req_len,
    output o_grant, o_done
  );
endinterface
`default_nettype wire

// File: rtl/cmd_tree_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmd_tree_sched : round-robin owner of one command tree; optional issue-cycle
// counter via CMD_TREE_SCHED_PERF_CNT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module cmd_tree_sched #(
  parameter int NUM_REQ         = 4,
  parameter int NUM_OUTPUT_DATA = 8,
  parameter int LEN_W           = 8,
  parameter int TREE_LATENCY    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  cmd_tree_sched_if.slave            bus,
  output logic                       o_tree_en,
  output logic [NUM_OUTPUT_DATA-1:0] o_tree_cmd,
  output logic                       o_busy
`ifdef CMD_TREE_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]                o_issue_cycles
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DRN_W = $clog2(TREE_LATENCY + 1);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_issue = 2'd1;
  localparam logic [1:0] c_drain = 2'd2;
  localparam logic [1:0] c_done  = 2'd3;

  logic [1:0]                 r_state;
  logic [PTR_W-1:0]           r_ptr;
  logic [PTR_W-1:0]           r_win;
  logic [LEN_W-1:0]           r_burst_cnt;
  logic [DRN_W-1:0]           r_drain_cnt;
  logic [NUM_REQ-1:0]         r_grant;
  logic [NUM_REQ-1:0]         r_done;
  logic                       r_tree_en;
  logic [NUM_OUTPUT_DATA-1:0] r_tree_cmd;
  logic                       r_busy;

  logic [NUM_OUTPUT_DATA-1:0] w_cmd_arr [NUM_REQ];
  logic [LEN_W-1:0]           w_len_arr [NUM_REQ];
  logic                       w_found;
  logic [PTR_W-1:0]           w_win;
  logic [PTR_W-1:0]           w_ptr_next;
  logic [NUM_OUTPUT_DATA-1:0] w_sel_cmd;
  logic [LEN_W-1:0]           w_burst_load;
  logic [NUM_REQ-1:0]         w_win_oh;
  logic [NUM_REQ-1:0]         w_rwin_oh;

  generate
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_slice
      assign w_cmd_arr[r] = bus.i_req_cmd[r*NUM_OUTPUT_DATA +: NUM_OUTPUT_DATA];
      assign w_len_arr[r] = bus.i_req_len[r*LEN_W +: LEN_W];
    end
  endgenerate

  // First requester at or above the pointer, wrapping around.
  always_comb begin : arb
    logic [PTR_W-1:0] v_idx;
    v_idx   = '0;
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_idx = PTR_W'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_found && bus.i_req[v_idx]) begin
        w_found = 1'b1;
        w_win   = v_idx;
      end
    end
  end

  assign w_ptr_next   = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
  assign w_sel_cmd    = w_cmd_arr[w_win];
  assign w_burst_load = (w_len_arr[w_win] == '0) ? LEN_W'(1) : w_len_arr[w_win];
  assign w_win_oh     = NUM_REQ'(1) << w_win;
  assign w_rwin_oh    = NUM_REQ'(1) << r_win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_idle;
      r_ptr       <= '0;
      r_win       <= '0;
      r_burst_cnt <= '0;
      r_drain_cnt <= '0;
      r_grant     <= '0;
      r_done      <= '0;
      r_tree_en   <= 1'b0;
      r_tree_cmd  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_grant <= '0;
      r_done  <= '0;
      case (r_state)
        c_idle: begin
          if (w_found) begin
            r_win   <= w_win;
            r_ptr   <= w_ptr_next;
            r_grant <= w_win_oh;
            r_busy  <= 1'b1;
            // An empty mask has nothing to send: grant and complete together.
            if (w_sel_cmd == '0) begin
              r_state <= c_done;
              r_done  <= w_win_oh;
            end else begin
              r_state     <= c_issue;
              r_tree_en   <= 1'b1;
              r_tree_cmd  <= w_sel_cmd;
              r_burst_cnt <= w_burst_load;
            end
          end
        end
        c_issue: begin
          if (r_burst_cnt <= LEN_W'(1)) begin
            r_state     <= c_drain;
            r_tree_en   <= 1'b0;
            r_tree_cmd  <= '0;
            r_burst_cnt <= '0;
            r_drain_cnt <= DRN_W'(TREE_LATENCY);
          end else begin
            r_burst_cnt <= r_burst_cnt - 1'b1;
          end
        end
        c_drain: begin
          if (r_drain_cnt <= DRN_W'(1)) begin
            r_state     <= c_done;
            r_done      <= w_rwin_oh;
            r_drain_cnt <= '0;
          end else begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
          end
        end
        c_done: begin
          r_state <= c_idle;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= c_idle;
          r_busy     <= 1'b0;
          r_tree_en  <= 1'b0;
          r_tree_cmd <= '0;
        end
      endcase
    end
  end

  assign bus.o_grant = r_grant;
  assign bus.o_done  = r_done;
  assign o_tree_en   = r_tree_en;
  assign o_tree_cmd  = r_tree_cmd;
  assign o_busy      = r_busy;

`ifdef CMD_TREE_SCHED_PERF_CNT_EN
  logic [31:0] r_issue_cycles;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issue_cycles <= '0;
    end else if (r_state == c_issue && r_issue_cycles != 32'hFFFF_FFFF) begin
      r_issue_cycles <= r_issue_cycles + 32'd1;
    end
  end

  assign o_issue_cycles = r_issue_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmd_tree_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cmd_tree_sched : scoreboard bench for cmd_tree_sched.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_cmd_tree_sched;
  localparam int NR  = 4;
  localparam int NOD = 8;
  localparam int LW  = 8;
  localparam int TL  = 4;

  logic           clk;
  logic           rst;
  logic           tree_en;
  logic [NOD-1:0] tree_cmd;
  logic           busy;
`ifdef CMD_TREE_SCHED_PERF_CNT_EN
  logic [31:0]    issue_cycles;
`endif

  int checks;
  int errors;
  int cyc;
  int exp_grant_q[$];
  int exp_done_q[$];

  cmd_tree_sched_if #(.NUM_REQ(NR), .NUM_OUTPUT_DATA(NOD), .LEN_W(LW)) bus ();

  cmd_tree_sched #(
    .NUM_REQ(NR), .NUM_OUTPUT_DATA(NOD), .LEN_W(LW), .TREE_LATENCY(TL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .o_tree_en  (tree_en),
    .o_tree_cmd (tree_cmd),
    .o_busy     (busy)
`ifdef CMD_TREE_SCHED_PERF_CNT_EN
    ,
    .o_issue_cycles (issue_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic set_req(input int r, input logic [NOD-1:0] cmd, input logic [LW-1:0] len);
    bus.i_req_cmd[r*NOD +: NOD] = cmd;
    bus.i_req_len[r*LW +: LW]   = len;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    bus.i_req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.i_req = '0;
    bus.i_req_cmd = '0;
    bus.i_req_len = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.o_grant, bus.o_done, tree_en, tree_cmd, busy} !== '0) begin
      errors++;
      $display("FAIL reset_held: got %h want 0", {bus.o_grant, bus.o_done, tree_en, tree_cmd, busy});
    end
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.o_grant, bus.o_done, tree_en, tree_cmd, busy} !== '0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got %h want 0", k, {bus.o_grant, bus.o_done, tree_en, tree_cmd, busy});
      end
    end
  endtask

  task automatic test_single();
    bit found;
    logic [NR-1:0] exp_d;
    set_req(2, 8'hA5, 8'd3);
    bus.i_req = 4'b0100;
    exp_grant_q.push_back(2);
    exp_done_q.push_back(2);
    found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (bus.o_grant != '0) found = 1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL single_grant_timeout: got none want grant");
      exp_grant_q.delete(); exp_done_q.delete();
      bus.i_req = '0;
      return;
    end
    bus.i_req = '0;
    checks++;
    exp_d = NR'(1) << exp_grant_q.pop_front();
    if (bus.o_grant !== exp_d) begin
      errors++;
      $display("FAIL single_grant: got %b want %b", bus.o_grant, exp_d);
    end
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(negedge clk);
      exp_d = (k == 7) ? NR'(1) << exp_done_q.pop_front() : '0;
      checks++;
      if ({tree_en, tree_cmd, bus.o_done} !== {(k <= 2), (k <= 2) ? 8'hA5 : 8'h00, exp_d}) begin
        errors++;
        $display("FAIL single_k%0d: got en=%b cmd=%h done=%b want en=%b cmd=%h done=%b",
                 k, tree_en, tree_cmd, bus.o_done, (k <= 2), (k <= 2) ? 8'hA5 : 8'h00, exp_d);
      end
    end
  endtask

  task automatic test_round_robin();
    int m_ptr, ngrant, ndone, g_cyc, d_cyc, idx;
    apply_reset();
    for (int r = 0; r < NR; r++) set_req(r, NOD'(8'h11 * (r + 1)), 8'd1);
    m_ptr = 0;
    for (int n = 0; n < 5; n++) begin
      exp_grant_q.push_back(m_ptr);
      exp_done_q.push_back(m_ptr);
      m_ptr = (m_ptr + 1) % NR;
    end
    bus.i_req = 4'hF;
    ngrant = 0; ndone = 0; g_cyc = -1; d_cyc = -1;
    for (int t = 0; t < 200 && ndone < 5; t++) begin
      @(negedge clk);
      if (bus.o_grant != '0) begin
        idx = (exp_grant_q.size() > 0) ? exp_grant_q.pop_front() : 0;
        checks++;
        if (bus.o_grant !== NR'(1) << idx || tree_cmd !== NOD'(8'h11 * (idx + 1))) begin
          errors++;
          $display("FAIL rr_grant[%0d]: got %b/%h want %b/%h", ngrant, bus.o_grant, tree_cmd,
                   NR'(1) << idx, NOD'(8'h11 * (idx + 1)));
        end
        if (d_cyc >= 0) begin
          checks++;
          if (cyc - d_cyc != 2) begin
            errors++;
            $display("FAIL rr_regrant_gap: got %0d want 2", cyc - d_cyc);
          end
        end
        g_cyc = cyc;
        ngrant++;
        if (ngrant == 5) bus.i_req = '0;
      end
      if (bus.o_done != '0) begin
        idx = (exp_done_q.size() > 0) ? exp_done_q.pop_front() : 0;
        checks++;
        if (bus.o_done !== NR'(1) << idx) begin
          errors++;
          $display("FAIL rr_done[%0d]: got %b want %b", ndone, bus.o_done, NR'(1) << idx);
        end
        checks++;
        if (cyc - g_cyc != 1 + TL) begin
          errors++;
          $display("FAIL rr_latency: got %0d want %0d", cyc - g_cyc, 1 + TL);
        end
        d_cyc = cyc;
        ndone++;
      end
    end
    bus.i_req = '0;
    if (ndone < 5) begin
      checks++; errors++;
      $display("FAIL rr_timeout: got %0d dones want 5", ndone);
    end
    exp_grant_q.delete(); exp_done_q.delete();
  endtask

  task automatic test_len_zero();
    bit found;
    int en_cnt, done_k;
    logic [NR-1:0] done_v, exp_d;
    set_req(1, 8'h01, 8'd0);
    bus.i_req = 4'b0010;
    exp_done_q.push_back(1);
    found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (bus.o_grant != '0) found = 1;
    end
    bus.i_req = '0;
    en_cnt = 0; done_k = -1; done_v = '0;
    for (int k = 0; k < 10 && found; k++) begin
      if (k > 0) @(negedge clk);
      if (tree_en) en_cnt++;
      if (bus.o_done != '0) begin done_k = k; done_v = bus.o_done; end
    end
    exp_d = NR'(1) << exp_done_q.pop_front();
    checks++;
    if (en_cnt != 1) begin
      errors++;
      $display("FAIL len0_issue_cycles: got %0d want 1", en_cnt);
    end
    checks++;
    if (done_k != 1 + TL || done_v !== exp_d) begin
      errors++;
      $display("FAIL len0_done: got k=%0d %b want k=%0d %b", done_k, done_v, 1 + TL, exp_d);
    end
  endtask

  task automatic test_zero_mask();
    bit found, saw_en, saw_done;
    logic [NR-1:0] exp_g, exp_d;
    set_req(3, 8'h00, 8'd5);
    bus.i_req = 4'b1000;
    exp_grant_q.push_back(3);
    exp_done_q.push_back(3);
    found = 0; saw_en = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (tree_en) saw_en = 1;
      if (bus.o_grant != '0) found = 1;
    end
    bus.i_req = '0;
    exp_g = NR'(1) << exp_grant_q.pop_front();
    exp_d = NR'(1) << exp_done_q.pop_front();
    checks++;
    if ({bus.o_grant, bus.o_done, busy, tree_en} !== {exp_g, exp_d, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL zmask_same_cycle: got g=%b d=%b busy=%b en=%b want g=%b d=%b busy=1 en=0",
               bus.o_grant, bus.o_done, busy, tree_en, exp_g, exp_d);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL zmask_back_idle: got busy=%b want 0", busy);
    end
    saw_done = 0;
    for (int k = 0; k < 10; k++) begin
      if (tree_en) saw_en = 1;
      if (bus.o_done != '0) saw_done = 1;
      @(negedge clk);
    end
    checks++;
    if (saw_en || saw_done) begin
      errors++;
      $display("FAIL zmask_quiet: got en=%b done=%b want 0 0", saw_en, saw_done);
    end
  endtask

  task automatic test_async_reset();
    bit found, stray;
    logic [NR-1:0] exp_g;
    set_req(2, 8'hFF, 8'd10);
    bus.i_req = 4'b0100;
    found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (bus.o_grant != '0) found = 1;
    end
    bus.i_req = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (tree_en !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre_issue: got en=%b want 1", tree_en);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({tree_en, tree_cmd, busy} !== '0) begin
      errors++;
      $display("FAIL arst_async_drop: got en=%b cmd=%h busy=%b want 0", tree_en, tree_cmd, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.o_done != '0 || bus.o_grant != '0 || tree_en) stray = 1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL arst_no_done: got activity want none");
    end
    for (int r = 0; r < NR; r++) set_req(r, 8'h0F, 8'd1);
    bus.i_req = 4'hF;
    exp_grant_q.push_back(0);
    exp_done_q.push_back(0);
    found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (bus.o_grant != '0) found = 1;
    end
    bus.i_req = '0;
    exp_g = NR'(1) << exp_grant_q.pop_front();
    checks++;
    if (bus.o_grant !== exp_g) begin
      errors++;
      $display("FAIL arst_ptr_reset: got %b want %b", bus.o_grant, exp_g);
    end
    found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (bus.o_done != '0) found = 1;
    end
    exp_g = NR'(1) << exp_done_q.pop_front();
    checks++;
    if (bus.o_done !== exp_g) begin
      errors++;
      $display("FAIL arst_next_done: got %b want %b", bus.o_done, exp_g);
    end
  endtask

`ifdef CMD_TREE_SCHED_PERF_CNT_EN
  task automatic test_perf_cnt();
    int lens[3];
    int exp_cnt;
    bit found;
    lens = '{2, 5, 1};
    apply_reset();
    exp_cnt = 0;
    for (int b = 0; b < 3; b++) begin
      set_req(0, 8'h3C, LW'(lens[b]));
      exp_cnt += (lens[b] == 0) ? 1 : lens[b];
      bus.i_req = 4'b0001;
      found = 0;
      for (int t = 0; t < 20 && !found; t++) begin
        @(negedge clk);
        if (bus.o_grant != '0) found = 1;
      end
      bus.i_req = '0;
      found = 0;
      for (int t = 0; t < 40 && !found; t++) begin
        @(negedge clk);
        if (bus.o_done != '0) found = 1;
      end
      if (!found) begin
        checks++; errors++;
        $display("FAIL perf_timeout[%0d]: got no done want done", b);
      end
    end
    @(negedge clk);
    checks++;
    if (issue_cycles !== 32'(exp_cnt)) begin
      errors++;
      $display("FAIL perf_issue_cycles: got %0d want %0d", issue_cycles, exp_cnt);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.i_req = '0;
    bus.i_req_cmd = '0;
    bus.i_req_len = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_len_zero();
    test_zero_mask();
    test_async_reset();
`ifdef CMD_TREE_SCHED_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
